// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sharing controller.
// Holds the ALU width, the opcode encoding and the controller state encoding.
package alu_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [2:0] {
    SUB  = 3'b000,
    ADD  = 3'b001,
    MUL  = 3'b010,
    DIV3 = 3'b011,
    AND  = 3'b100,
    SHL  = 3'b101,
    SHR  = 3'b110,
    NOP  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } share_state_e;

  // Turn a requester id into its one-hot select.
  function automatic logic [1:0] onehot2(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_arb2.sv
// Two-way grant logic for the ALU sharing controller.
// ALU_SHARE_RR_EN selects round-robin on a tie; otherwise requester 0 wins.
module arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

`ifdef ALU_SHARE_RR_EN
  // Round-robin: on a tie grant the requester that was not granted last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end
`else
  // The pointer has no meaning under fixed priority.
  logic unused_last;
  assign unused_last = last;

  // Fixed priority: requester 0 always wins a tie.
  always_comb begin
    gnt = {req[1] & ~req[0], req[0]};
  end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters.
// Grants one request, registers its operands onto the ALU, captures the result
// one cycle later and returns it over a per-requester valid/ready response.
// Build option: ALU_SHARE_RR_EN enables round-robin arbitration.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int N_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0][W-1:0]   req_a,
  input  logic [N_REQ-1:0][W-1:0]   req_b,
  input  logic [N_REQ-1:0][2:0]     req_op,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [W-1:0]              rsp_result,
  output logic                      rsp_zero,
  output logic [W-1:0]              alu_a,
  output logic [W-1:0]              alu_b,
  output logic [2:0]                alu_ctrl,
  input  logic [W-1:0]              alu_result,
  input  logic                      alu_zero
);

  share_state_e state_q;
  logic         id_q;
  logic         last_q;
  logic [1:0]   gnt;

`ifndef ALU_SHARE_RR_EN
  // Without round-robin the pointer is a constant that favours requester 0.
  assign last_q = 1'b1;
`endif

  arb2 u_arb (
    .req  (req_valid),
    .last (last_q),
    .gnt  (gnt)
  );

  // Accept is combinational in IDLE and forced low while reset is held.
  assign req_ready = (state_q == IDLE && rst_n) ? gnt : '0;

  // Controller FSM: grant and register operands, capture ALU output, hold response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_valid  <= '0;
`ifdef ALU_SHARE_RR_EN
      last_q     <= 1'b1;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignment so every update sees pre-edge values.
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            id_q     <= gnt[1];
            alu_a    <= req_a[gnt[1]];
            alu_b    <= req_b[gnt[1]];
            alu_ctrl <= req_op[gnt[1]];
`ifdef ALU_SHARE_RR_EN
            last_q   <= gnt[1];
`endif
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= onehot2(id_q);
          state_q    <= RESP;
        end
        RESP: begin
          if (rsp_ready[id_q]) begin
            rsp_valid <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a behavioural ALU beside it.
// Expected responses are queued at accept time and popped when rsp_valid rises.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][15:0]  req_a;
  logic [1:0][15:0]  req_b;
  logic [1:0][2:0]   req_op;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [15:0]       rsp_result;
  logic              rsp_zero;
  logic [15:0]       alu_a;
  logic [15:0]       alu_b;
  logic [2:0]        alu_ctrl;
  logic [15:0]       alu_result;
  logic              alu_zero;

  typedef struct packed {
    logic        id;
    logic [15:0] result;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  alu_share_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  // Returns {zero, result} for an ALU operation, mod 2^16.
  function automatic logic [16:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] r;
    case (op)
      SUB:     r = a - b;
      ADD:     r = a + b;
      MUL:     r = 16'(a * b);
      DIV3:    r = a / 16'd3;
      AND:     r = a & b;
      SHL:     r = a << b;
      SHR:     r = a >> b;
      default: r = 16'h0000;
    endcase
    return {(r == 16'h0000), r};
  endfunction

  // Behavioural ALU that sits beside the controller.
  always_comb begin
    {alu_zero, alu_result} = alu_ref(alu_ctrl, alu_a, alu_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic id, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b);
    logic [16:0] r;
    exp_t        e;
    r = alu_ref(op, a, b);
    e.id     = id;
    e.result = r[15:0];
    e.zero   = r[16];
    sb.push_back(e);
  endtask

  // Compare the current response against the oldest queued expectation.
  task automatic check_rsp();
    exp_t e;
    check("sb_nonempty", (sb.size() == 0), 0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rsp_valid", rsp_valid, onehot2(e.id));
      check("rsp_result", rsp_result, e.result);
      check("rsp_zero", rsp_zero, e.zero);
    end
  endtask

  // One isolated transaction with cycle-exact timing checks.
  task automatic send_one(input logic id, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b);
    req_a[id]     = a;
    req_b[id]     = b;
    req_op[id]    = op;
    req_valid[id] = 1'b1;
    #1;
    check("accept_ready", req_ready, onehot2(id));
    push_exp(id, op, a, b);
    tick();
    req_valid[id] = 1'b0;
    check("exec_alu_a", alu_a, a);
    check("exec_alu_b", alu_b, b);
    check("exec_alu_ctrl", alu_ctrl, op);
    check("exec_no_rsp", rsp_valid, 2'b00);
    check("exec_no_ready", req_ready, 2'b00);
    tick();
    check_rsp();
    rsp_ready = onehot2(id);
    tick();
    rsp_ready = 2'b00;
    check("after_hs_rsp", rsp_valid, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exp_id;
    logic [15:0] held;

    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 2'b00;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_result", rsp_result, 16'h0000);
    check("rst_rsp_zero", rsp_zero, 1'b0);
    check("rst_alu_a", alu_a, 16'h0000);
    check("rst_alu_b", alu_b, 16'h0000);
    check("rst_alu_ctrl", alu_ctrl, 3'b000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single requests from each side.
    send_one(1'b0, ADD, 16'd5, 16'd3);
    send_one(1'b1, SUB, 16'd7, 16'd7);

    // Both valid continuously; pointer last=1 so requester 0 wins first.
    req_a[0] = 16'd10;     req_b[0] = 16'd20;     req_op[0] = ADD;
    req_a[1] = 16'h0100;   req_b[1] = 16'h0100;   req_op[1] = MUL;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_SHARE_RR_EN
      exp_id = k[0];
`else
      exp_id = 1'b0;
`endif
      #1;
      check("tie_grant", req_ready, onehot2(exp_id));
      push_exp(exp_id, req_op[exp_id], req_a[exp_id], req_b[exp_id]);
      tick();
      check("tie_alu_ctrl", alu_ctrl, req_op[exp_id]);
      tick();
      check_rsp();
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();

    // Response back-pressure with requester 1 waiting.
    held = alu_ref(AND, 16'h1234, 16'h00FF) >> 0;
    req_a[0] = 16'h1234; req_b[0] = 16'h00FF; req_op[0] = AND;
    req_valid = 2'b01;
    #1;
    check("stall_accept", req_ready, 2'b01);
    push_exp(1'b0, AND, 16'h1234, 16'h00FF);
    tick();
    req_valid[0] = 1'b0;
    req_a[1] = 16'h8000; req_b[1] = 16'd4; req_op[1] = SHR;
    req_valid[1] = 1'b1;
    #1;
    check("busy_no_ready", req_ready, 2'b00);
    tick();
    check_rsp();
    rsp_ready = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stall_rsp_valid", rsp_valid, 2'b01);
      check("stall_rsp_result", rsp_result, held);
      check("stall_no_accept", req_ready, 2'b00);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    check("resume_accept", req_ready, 2'b10);
    check("resume_rsp_clear", rsp_valid, 2'b00);
    push_exp(1'b1, SHR, 16'h8000, 16'd4);
    tick();
    req_valid = 2'b00;
    tick();
    check_rsp();
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;

    // Reset during EXEC discards the transaction.
    req_a[0] = 16'd100; req_b[0] = 16'd0; req_op[0] = DIV3;
    req_valid = 2'b01;
    #1;
    check("pre_rst_accept", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    check("pre_rst_alu_a", alu_a, 16'd100);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_alu_a", alu_a, 16'h0000);
    check("mid_rst_alu_ctrl", alu_ctrl, 3'b000);
    check("mid_rst_rsp_valid", rsp_valid, 2'b00);
    check("mid_rst_rsp_result", rsp_result, 16'h0000);
    check("mid_rst_req_ready", req_ready, 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_no_rsp", rsp_valid, 2'b00);
    send_one(1'b1, NOP, 16'd7, 16'd9);
    send_one(1'b0, SHL, 16'd1, 16'd15);
    send_one(1'b0, DIV3, 16'd100, 16'd0);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
